// File: rtl/mem_ro_rsp.sv
// mem_ro_rsp: read-only word memory responder for the memory side of cache_ro.
// Accepts one word-read request at a time on i_mem_req/i_mem_addr and returns
// the word with a one-cycle o_mem_ack pulse after LATENCY wait cycles. The
// backing array is filled through an independent load port.
//
// Optional feature macro: MEM_RO_RSP_OOR_EN
//   defined   -> adds o_mem_err; requests whose address bits above the array
//                index are nonzero return 32'hDEAD_BEEF and pulse o_mem_err
//                together with o_mem_ack.
//   undefined -> no o_mem_err port; addresses alias modulo 2^DEPTH_LOG2.
//
// DEPTH_LOG2 must be below 30 so that at least one upper address bit exists.
module mem_ro_rsp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  i_ck,
  input  logic                  i_rst,
  input  logic                  i_mem_req,
  input  logic [29:0]           i_mem_addr,
  output logic                  o_mem_ack,
  output logic [31:0]           o_mem_data,
  input  logic                  i_ld_we,
  input  logic [DEPTH_LOG2-1:0] i_ld_addr,
  input  logic [31:0]           i_ld_data,
  output logic                  o_busy
`ifdef MEM_RO_RSP_OOR_EN
  ,
  output logic                  o_mem_err
`endif
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT      = 4'(LATENCY);
  localparam logic [31:0] OOR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [29:0]             addr_q;
  logic                    ack_q;
  logic                    busy_q;
  logic [31:0]             data_q;

  // Backing store; contents are deliberately not reset.
  logic [31:0]             mem [DEPTH];

  logic [29:0]             rd_addr;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    enter_ack;

  // Address used for the array read on the edge that enters ACK. With zero
  // latency ACK is entered straight from IDLE, so the live request address is
  // used because the latched copy is only being written on that same edge.
  always_comb begin
    rd_addr   = (state_q == ST_IDLE) ? i_mem_addr : addr_q;
    rd_idx    = rd_addr[DEPTH_LOG2-1:0];
    enter_ack = 1'b0;
    if (state_q == ST_IDLE && i_mem_req && LAT == 4'd0) begin
      enter_ack = 1'b1;
    end
    if (state_q == ST_WAIT && cnt_q == 4'd1) begin
      enter_ack = 1'b1;
    end
  end

`ifdef MEM_RO_RSP_OOR_EN
  logic oor;
  logic err_q;

  // Any nonzero bit above the array index marks the request out of range.
  always_comb begin
    oor = (rd_addr >> DEPTH_LOG2) != 30'd0;
  end

  assign o_mem_err = err_q;
`else
  // Upper address bits only matter when range checking is built in.
  logic unused_addr_hi;
  assign unused_addr_hi = ^rd_addr[29:DEPTH_LOG2];
`endif

  // Load port: writes land in any FSM state but never while in reset.
  always_ff @(posedge i_ck) begin
    if (!i_rst && i_ld_we) begin
      mem[i_ld_addr] <= i_ld_data;
    end
  end

  // Request FSM with registered ack/busy/data. The array read happens with a
  // non-blocking assignment, so a load write to the same index on the ACK
  // entry edge is not seen and the old word is returned.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 30'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= 32'h0;
`ifdef MEM_RO_RSP_OOR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef MEM_RO_RSP_OOR_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (i_mem_req) begin
            addr_q <= i_mem_addr;
            cnt_q  <= LAT;
            busy_q <= 1'b1;
            state_q <= (LAT == 4'd0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Request is not sampled here; the counter alone decides the exit.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          // A request still high here is ignored; IDLE will pick it up.
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase

      if (enter_ack) begin
        ack_q <= 1'b1;
`ifdef MEM_RO_RSP_OOR_EN
        err_q  <= oor;
        data_q <= oor ? OOR_WORD : mem[rd_idx];
`else
        data_q <= mem[rd_idx];
`endif
      end
    end
  end

  assign o_mem_ack  = ack_q;
  assign o_mem_data = data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_mem_ro_rsp.sv
// tb_mem_ro_rsp: randomized self-checking bench for mem_ro_rsp. Two instances
// run side by side, one with LATENCY=2 and one with LATENCY=0. A plain array
// model of the memory plus the request-to-ack timing rule supply every
// expected value.
module tb_mem_ro_rsp;

  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic        req     [2];
  logic [29:0] maddr   [2];
  logic        ack     [2];
  logic [31:0] rdata   [2];
  logic        ld_we   [2];
  logic [9:0]  ld_addr [2];
  logic [31:0] ld_data [2];
  logic        busy    [2];
`ifdef MEM_RO_RSP_OOR_EN
  logic        err     [2];
`endif

  logic [31:0] model_mem [2][DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_ro_rsp #(
      .DEPTH_LOG2(DL),
      .LATENCY   ((gi == 0) ? 2 : 0)
    ) u_dut (
      .i_ck      (clk),
      .i_rst     (rst),
      .i_mem_req (req[gi]),
      .i_mem_addr(maddr[gi]),
      .o_mem_ack (ack[gi]),
      .o_mem_data(rdata[gi]),
      .i_ld_we   (ld_we[gi]),
      .i_ld_addr (ld_addr[gi]),
      .i_ld_data (ld_data[gi]),
      .o_busy    (busy[gi])
`ifdef MEM_RO_RSP_OOR_EN
      ,
      .o_mem_err (err[gi])
`endif
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected word and error flag for a read, straight from the address rules.
  task automatic ref_read(input int k, input logic [29:0] a,
                          output logic [31:0] d, output logic e);
    int hi;
    int lo;
    hi = int'(a) / DEPTH;
    lo = int'(a) % DEPTH;
    e  = 1'b0;
    d  = model_mem[k][lo];
`ifdef MEM_RO_RSP_OOR_EN
    if (hi != 0) begin
      d = 32'hDEAD_BEEF;
      e = 1'b1;
    end
`else
    if (hi < 0) d = 32'h0;
`endif
  endtask

  task automatic load(input int k, input int a, input logic [31:0] d);
    ld_we[k]   = 1'b1;
    ld_addr[k] = 10'(a);
    ld_data[k] = d;
    @(posedge clk); #1;
    ld_we[k] = 1'b0;
    model_mem[k][a] = d;
  endtask

  // Issue one request and follow it to its ack; returns the DUT idle.
  task automatic do_read(input int k, input logic [29:0] a, input string tag);
    int          lat;
    int          got;
    logic [31:0] exp_d;
    logic        exp_e;
    lat = lat_of(k);
    got = -1;
    ref_read(k, a, exp_d, exp_e);
    req[k]   = 1'b1;
    maddr[k] = a;
    for (int i = 1; i <= lat + 6 && got < 0; i++) begin
      @(posedge clk); #1;
      if (i == 1) check_eq({tag, "_busy"}, 32'(busy[k]), 32'd1);
      if (ack[k]) begin
        got = i;
        check_eq({tag, "_data"}, rdata[k], exp_d);
`ifdef MEM_RO_RSP_OOR_EN
        check_eq({tag, "_err"}, 32'(err[k]), 32'(exp_e));
`endif
        req[k] = 1'b0;
      end
    end
    check_eq({tag, "_lat"}, 32'(got), 32'(lat + 1));
    req[k] = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 32'(ack[k]), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy[k]), 32'd0);
    check_eq({tag, "_hold"}, rdata[k], exp_d);
`ifdef MEM_RO_RSP_OOR_EN
    check_eq({tag, "_errpulse"}, 32'(err[k]), 32'd0);
`endif
    $display("read dut=%0d addr=%h data=%h exp=%h ack_cycle=%0d", k, a, rdata[k], exp_d, got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [29:0] a;
    int          lat;
    int          n_ack;
    int          first_c;
    int          second_c;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; maddr[k] = '0; ld_we[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill both arrays with random words so every read has a defined answer.
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        ld_we[k] = 1'b1; ld_addr[k] = 10'(i); ld_data[k] = $urandom;
        model_mem[k][i] = ld_data[k];
      end
      @(posedge clk); #1;
    end
    ld_we[0] = 1'b0; ld_we[1] = 1'b0;

    // Reset held for two cycles with a request pending.
    rst = 1'b1; req[0] = 1'b1; maddr[0] = 30'd7;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("rst_ack", 32'(ack[0]), 32'd0);
      check_eq("rst_data", rdata[0], 32'h0);
      check_eq("rst_busy", 32'(busy[0]), 32'd0);
    end
    rst = 1'b0;
    do_read(0, 30'd7, "rst_release");

    // Basic read.
    load(0, 5, 32'h1234_5678);
    do_read(0, 30'd5, "basic");

    // Back-to-back with request held through ACK.
    load(0, 1, 32'h0000_00A1);
    load(0, 2, 32'h0000_00A2);
    lat = lat_of(0); n_ack = 0; first_c = -1; second_c = -1;
    req[0] = 1'b1; maddr[0] = 30'd1;
    for (int i = 1; i <= 2 * lat + 8; i++) begin
      @(posedge clk); #1;
      if (ack[0]) begin
        n_ack++;
        if (n_ack == 1) begin
          first_c = i;
          check_eq("b2b_data1", rdata[0], 32'h0000_00A1);
          maddr[0] = 30'd2;
        end else begin
          second_c = i;
          check_eq("b2b_data2", rdata[0], 32'h0000_00A2);
          req[0] = 1'b0;
        end
      end
    end
    req[0] = 1'b0;
    check_eq("b2b_count", 32'(n_ack), 32'd2);
    check_eq("b2b_first", 32'(first_c), 32'(lat + 1));
    check_eq("b2b_gap", 32'(second_c - first_c), 32'(lat + 2));
    $display("b2b dut=0 acks=%0d first=%0d second=%0d", n_ack, first_c, second_c);

    // Collision on the ACK-entry edge with zero latency.
    load(1, 3, 32'h0000_0D1D);
    req[1] = 1'b1; maddr[1] = 30'd3;
    ld_we[1] = 1'b1; ld_addr[1] = 10'd3; ld_data[1] = 32'h0000_0E3E;
    @(posedge clk); #1;
    ld_we[1] = 1'b0; req[1] = 1'b0;
    model_mem[1][3] = 32'h0000_0E3E;
    check_eq("coll_ack", 32'(ack[1]), 32'd1);
    check_eq("coll_old", rdata[1], 32'h0000_0D1D);
    @(posedge clk); #1;
    check_eq("coll_pulse", 32'(ack[1]), 32'd0);
    $display("collision dut=1 addr=3 returned old word");
    do_read(1, 30'd3, "coll_new");

    // Reset while waiting drops the request.
    req[0] = 1'b1; maddr[0] = 30'd9;
    @(posedge clk); #1;
    check_eq("rstw_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rstw_idle", 32'(busy[0]), 32'd0);
    n_ack = 32'(ack[0]);
    repeat (6) begin
      @(posedge clk); #1;
      n_ack += int'(ack[0]);
    end
    check_eq("rstw_noack", 32'(n_ack), 32'd0);
    $display("reset-in-wait dut=0 acks_after_abort=%0d", n_ack);
    do_read(0, 30'd9, "rstw_reissue");

    // Address just past the array.
    do_read(0, 30'h400, "oor0");
    do_read(1, 30'h400, "oor1");

    // Random mix of loads and reads, including high-address reads.
    for (int it = 0; it < 80; it++) begin
      int k;
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        load(k, int'($urandom_range(0, DEPTH - 1)), d);
      end else begin
        a = 30'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 3) == 0) a[29:10] = 20'($urandom_range(1, 20'hFFFFF));
        do_read(k, a, "rand");
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ro_rsp.md
# mem_ro_rsp

Read-only memory responder for the memory side of `cache_ro`. It accepts word-read requests on the `mem_req`/`mem_addr` interface and returns one 32-bit word per request with `mem_ack` after a programmable latency. Contents come from a backing array that the bench or a boot loader fills through a separate load port. The block stands in for the external instruction memory in cache simulations and small integrations.

## Interface
- `DEPTH_LOG2`, default 10: backing array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 2: extra wait cycles between request capture and ack. Range 0..15.
- `i_ck` in 1: clock, rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_mem_req` in 1: read request from the cache. Held high until acked.
- `i_mem_addr` in 30: word address. Held stable while `i_mem_req` is high.
- `o_mem_ack` out 1: one-cycle pulse; `o_mem_data` is valid in the same cycle.
- `o_mem_data` out 32: read data.
- `i_ld_we` in 1: load-port write enable.
- `i_ld_addr` in DEPTH_LOG2: load-port word address.
- `i_ld_data` in 32: load-port write data.
- `o_busy` out 1: high in WAIT and ACK.
- `o_mem_err` out 1: present only when `MEM_RO_RSP_OOR_EN` is defined. One-cycle pulse, coincident with `o_mem_ack`.

## Operation
- The FSM has three states: IDLE, WAIT, ACK.
- **IDLE:** if `i_mem_req` = 1 at a rising edge, latch `i_mem_addr` and load the latency counter with LATENCY.
  - If LATENCY = 0, go to ACK.
  - Otherwise go to WAIT.
- **WAIT:** decrement the counter each cycle. When the counter reaches 1, the next edge enters ACK. WAIT therefore lasts exactly LATENCY cycles. `i_mem_req` is not sampled in WAIT.
- **ACK:** `o_mem_ack` = 1 for exactly one cycle, then return unconditionally to IDLE. A request still high during ACK is ignored. A request still high in the following IDLE cycle is treated as a new request.
- **Read path:** `o_mem_data` is registered from `array[latched_addr[DEPTH_LOG2-1:0]]` on the edge that enters ACK. It holds its value until the next ACK entry and is not cleared after ack.
- **Load port:** on any edge with `i_ld_we` = 1 and `i_rst` = 0, write `array[i_ld_addr]` = `i_ld_data`. Writes are accepted in every FSM state.
- **Read/write collision:** a load write at the same edge that enters ACK, to the same index, is not visible. The old word is returned.
- **Address handling:** only `latched_addr[DEPTH_LOG2-1:0]` indexes the array. Higher address bits are governed by the Configuration section.

## Timing
- **Reset values:** state = IDLE, `o_mem_ack` = 0, `o_mem_data` = 32'h0, `o_busy` = 0, `o_mem_err` = 0, counter = 0.
- Array contents are not reset.
- **Reset mid-operation** (WAIT or ACK): the pending request is dropped, with no ack, and the FSM returns to IDLE on that edge. Load writes are ignored while `i_rst` = 1.
- **Latency:** the request is sampled at edge N, and `o_mem_ack` is high in the cycle following edge N+LATENCY. The total is LATENCY+1 cycles from sampling to ack.
- **Throughput:** one request per LATENCY+2 cycles at most.
- `o_busy` rises on the edge after request capture and falls on the edge leaving ACK.

## Configuration
- **`MEM_RO_RSP_OOR_EN` defined:**
  - If `latched_addr[29:DEPTH_LOG2]` is nonzero, ACK returns `o_mem_data` = 32'hDEAD_BEEF and pulses `o_mem_err` with `o_mem_ack`.
  - Timing is unchanged, and the array is not read.
- **`MEM_RO_RSP_OOR_EN` undefined:**
  - The `o_mem_err` port is absent.
  - Addresses alias modulo 2^DEPTH_LOG2 with no error indication.

## Test plan
- **Reset outputs:** hold `i_rst` = 1 for 2 cycles with `i_mem_req` = 1 -> `o_mem_ack` = 0, `o_mem_data` = 0, `o_busy` = 0 throughout. The first ack comes LATENCY+1 cycles after release.
- **Basic read, LATENCY = 2:** load `array[5]` = 32'h1234_5678, then request addr 5 -> ack exactly 3 cycles after the sampling edge, for exactly 1 cycle, with data 32'h1234_5678.
- **Back-to-back requests:** keep `i_mem_req` high through ACK for addrs 1 then 2 (= 32'hA1, 32'hA2) -> two single-cycle acks 4 cycles apart, returning 32'hA1 then 32'hA2. There is no ack for the cycle in which req stays high during ACK.
- **Collision and LATENCY = 0:** with LATENCY = 0, write `array[3]` = 32'hNEW on the edge entering ACK, old value 32'hOLD -> ack on the cycle after request, returning 32'hOLD. A following read of addr 3 returns 32'hNEW.
- **Reset in WAIT:** assert `i_rst` for 1 cycle during WAIT -> no ack for the aborted request, and the FSM is IDLE. A re-issued request acks normally.
- **Out-of-range address, DEPTH_LOG2 = 10, addr 30'h400:**
  - With `MEM_RO_RSP_OOR_EN` defined -> data 32'hDEAD_BEEF and `o_mem_err` = 1 with ack.
  - Without the macro -> returns `array[0]`.
